// File: rtl/block_counter_modn_if.sv
// block_counter_modn_if
//   Control/status bundle for block_counter_modn.
//   master : drives En, Up_Down, Load, Load_Value; observes Output, Tick, Carry
//   slave  : the counter side of the same signals
//   Load_Value/Output pack digit k at bits [k*WIDTH +: WIDTH].
interface block_counter_modn_if #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 2
);
    logic                      En;
    logic                      Up_Down;
    logic                      Load;
    logic [DIGITS*WIDTH-1:0]   Load_Value;
    logic [DIGITS*WIDTH-1:0]   Output;
    logic                      Tick;
    logic                      Carry;

    modport master (
        output En, Up_Down, Load, Load_Value,
        input  Output, Tick, Carry
    );

    modport slave (
        input  En, Up_Down, Load, Load_Value,
        output Output, Tick, Carry
    );
endinterface

// File: rtl/block_counter_modn.sv
// block_counter_modn
//   Cascadable modulo-MODULUS up/down counter of DIGITS digits, stepped by an
//   internal prescaler that raises a one-cycle Tick every CLK_HZ/TICK_HZ cycles.
//   Everything runs on clk_50M; no derived clocks.
// Ports:
//   clk_50M : clock, rising edge
//   Reset   : asynchronous reset, active low
//   bus     : slave side of block_counter_modn_if
//             En/Up_Down sampled together with Tick, Load has priority,
//             Output/Tick/Carry are registered.
module block_counter_modn #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1,
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4,
    parameter int DIGITS  = 2
) (
    input logic                  clk_50M,
    input logic                  Reset,
    block_counter_modn_if.slave  bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PMAX = PW'(DIV - 1);
    // Highest legal digit value; digits are compared against it explicitly so
    // a non-power-of-two modulus never relies on binary overflow.
    localparam logic [WIDTH-1:0] DMAX = WIDTH'(MODULUS - 1);

    logic [PW-1:0]                  presc_q, presc_d;
    logic                           tick_q, tick_d;
    logic [DIGITS-1:0][WIDTH-1:0]   digit_q, digit_d;
    logic                           carry_q, carry_d;
    logic                           chain;
    logic [WIDTH-1:0]               field;

    always_comb begin
        presc_d = (presc_q == PMAX) ? '0 : presc_q + 1'b1;
        tick_d  = (presc_q == PMAX);
        digit_d = digit_q;
        carry_d = 1'b0;
        chain   = 1'b1;
        field   = '0;
        if (bus.Load) begin
            // Out-of-range load fields clamp to the top digit value.
            for (int k = 0; k < DIGITS; k++) begin
                field      = bus.Load_Value[k*WIDTH +: WIDTH];
                digit_d[k] = (field > DMAX) ? DMAX : field;
            end
        end else if (tick_q && bus.En) begin
            // chain = this digit receives the increment/borrow; it survives
            // past the last digit only when every digit wrapped.
            for (int k = 0; k < DIGITS; k++) begin
                if (chain) begin
                    if (bus.Up_Down) begin
                        if (digit_q[k] == DMAX) begin
                            digit_d[k] = '0;
                        end else begin
                            digit_d[k] = digit_q[k] + 1'b1;
                            chain      = 1'b0;
                        end
                    end else begin
                        if (digit_q[k] == '0) begin
                            digit_d[k] = DMAX;
                        end else begin
                            digit_d[k] = digit_q[k] - 1'b1;
                            chain      = 1'b0;
                        end
                    end
                end
            end
            carry_d = chain;
        end
    end

    always_ff @(posedge clk_50M or negedge Reset) begin
        if (!Reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            digit_q <= '0;
            carry_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            digit_q <= digit_d;
            carry_q <= carry_d;
        end
    end

    assign bus.Output = digit_q;
    assign bus.Tick   = tick_q;
    assign bus.Carry  = carry_q;
endmodule

// File: tb/tb_block_counter_modn.sv
// tb_block_counter_modn
//   dut_a: DIV=4, decimal two-digit counter. dut_b: DIV=4, single mod-6 digit.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
//   ecnt counts rising edges since the active DUT's reset release.
module tb_block_counter_modn;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   ecnt;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    block_counter_modn_if #(.WIDTH(4), .DIGITS(2)) ifa ();
    block_counter_modn_if #(.WIDTH(3), .DIGITS(1)) ifb ();

    block_counter_modn #(.CLK_HZ(4), .TICK_HZ(1), .MODULUS(10), .WIDTH(4), .DIGITS(2))
        dut_a (.clk_50M(clk), .Reset(rst_a), .bus(ifa));
    block_counter_modn #(.CLK_HZ(4), .TICK_HZ(1), .MODULUS(6), .WIDTH(3), .DIGITS(1))
        dut_b (.clk_50M(clk), .Reset(rst_b), .bus(ifb));

    typedef struct {
        logic       ld;
        logic [7:0] lv;
        logic       en;
        logic       up;
        int         n;     // edges this row is held for
        logic [7:0] out;   // expected Output after each of those edges
        logic       cy;    // expected Carry after each of those edges
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, ecnt, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        step();
        rst_a = 1'b1;
        ecnt  = 0;
    endtask

    function automatic logic [7:0] bcd(input int k);
        logic [3:0] hi, lo;
        hi = 4'(k / 10);
        lo = 4'(k % 10);
        return {hi, lo};
    endfunction

    initial begin
        tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b1,  4, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 8'h57, 1'b1, 1'b1,  1, 8'h57, 1'b0}; // load beats tick
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1,  3, 8'h57, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1,  1, 8'h58, 1'b0};
        tbl[4]  = '{1'b1, 8'hAF, 1'b1, 1'b1,  1, 8'h99, 1'b0}; // clamp both digits
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1,  2, 8'h99, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1,  1, 8'h00, 1'b1}; // wrap from load
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1,  1, 8'h00, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 12, 8'h00, 1'b0}; // 3 ticks disabled
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1,  2, 8'h00, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1,  1, 8'h01, 1'b0}; // exactly +1
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1,  3, 8'h01, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0,  1, 8'h00, 1'b0}; // direction flip
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0,  3, 8'h00, 1'b0};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0,  1, 8'h99, 1'b1}; // borrow wrap
        tbl[15] = '{1'b1, 8'h3C, 1'b1, 1'b0,  1, 8'h39, 1'b0}; // low digit clamp

        ecnt = 0;
        rst_a = 1'b0; rst_b = 1'b0;
        ifa.En = 1'b1; ifa.Up_Down = 1'b1; ifa.Load = 1'b0; ifa.Load_Value = '0;
        ifb.En = 1'b1; ifb.Up_Down = 1'b1; ifb.Load = 1'b0; ifb.Load_Value = '0;

        // Reset state, with an edge seen while held.
        step();
        chk("rst_out", 32'(ifa.Output), 0);
        chk("rst_tick", 32'(ifa.Tick), 0);
        chk("rst_carry", 32'(ifa.Carry), 0);
        chk("rst_b_out", 32'(ifb.Output), 0);
        rst_a = 1'b1;
        ecnt  = 0;

        // Count up through a full 00..99 wrap.
        for (int e = 1; e <= 402; e++) begin
            step();
            chk("up_out", 32'(ifa.Output), 32'(bcd(((ecnt - 1) / 4) % 100)));
            chk("up_carry", 32'(ifa.Carry), 32'(ecnt == 401));
            chk("up_tick", 32'(ifa.Tick), 32'(ecnt % 4 == 0));
        end

        // Down from zero.
        ifa.Up_Down = 1'b0;
        reset_a();
        for (int e = 1; e <= 4; e++) begin
            step();
            chk("dn_tick", 32'(ifa.Tick), 32'(e == 4));
            chk("dn_hold", 32'(ifa.Output), 0);
        end
        step();
        chk("dn_wrap_out", 32'(ifa.Output), 32'h99);
        chk("dn_wrap_carry", 32'(ifa.Carry), 1);
        step();
        chk("dn_carry_drop", 32'(ifa.Carry), 0);
        step(); step();
        chk("dn_pre", 32'(ifa.Output), 32'h99);
        step();
        chk("dn_next", 32'(ifa.Output), 32'h98);

        // Load priority / clamp / enable hold / direction, table driven.
        ifa.Up_Down = 1'b1;
        reset_a();
        for (int i = 0; i < 16; i++) begin
            ifa.Load       = tbl[i].ld;
            ifa.Load_Value = tbl[i].lv;
            ifa.En         = tbl[i].en;
            ifa.Up_Down    = tbl[i].up;
            for (int r = 0; r < tbl[i].n; r++) begin
                step();
                chk("tbl_out", 32'(ifa.Output), 32'(tbl[i].out));
                chk("tbl_carry", 32'(ifa.Carry), 32'(tbl[i].cy));
                chk("tbl_tick", 32'(ifa.Tick), 32'(ecnt % 4 == 0));
            end
        end

        // Asynchronous reset mid-operation while showing 0x42 with Tick high.
        ifa.Load = 1'b1; ifa.Load_Value = 8'h42; ifa.En = 1'b0;
        step();
        ifa.Load = 1'b0;
        step();
        chk("ar_pre_out", 32'(ifa.Output), 32'h42);
        chk("ar_pre_tick", 32'(ifa.Tick), 1);
        #2;
        rst_a = 1'b0;
        #1;
        chk("ar_out", 32'(ifa.Output), 0);
        chk("ar_tick", 32'(ifa.Tick), 0);
        chk("ar_carry", 32'(ifa.Carry), 0);
        ifa.En = 1'b1; ifa.Up_Down = 1'b1;
        step();
        rst_a = 1'b1;
        ecnt  = 0;
        for (int e = 1; e <= 5; e++) begin
            step();
            chk("ar_tick_restart", 32'(ifa.Tick), 32'(e == 4));
            chk("ar_count", 32'(ifa.Output), 32'(e == 5));
        end

        // Non-power-of-two modulus on dut_b.
        rst_a = 1'b0;
        rst_b = 1'b1;
        ecnt  = 0;
        for (int e = 1; e <= 33; e++) begin
            step();
            chk("m6_out", 32'(ifb.Output), 32'(((ecnt - 1) / 4) % 6));
            chk("m6_range", 32'(ifb.Output < 3'd6), 1);
            chk("m6_carry", 32'(ifb.Carry), 32'(ecnt == 25));
            chk("m6_tick", 32'(ifb.Tick), 32'(ecnt % 4 == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
